// File: rtl/kolibri_pkg.sv
// Shared bus-timing definitions for the Kolibri glue: Gray-coded 6309 phase
// states, default timing constants and the E/Q level decode.
package kolibri_pkg;

   typedef enum logic [1:0] {
      S_EF = 2'b00,
      S_QR = 2'b01,
      S_ER = 2'b11,
      S_QF = 2'b10
   } phase_e;

   localparam int unsigned PHASE_DEFAULT    = 4;
   localparam int unsigned WAIT_MAX_DEFAULT = 64;

   function automatic logic e_level(input phase_e s);
      return (s == S_ER) || (s == S_QF);
   endfunction

   function automatic logic q_level(input phase_e s);
      return (s == S_QR) || (s == S_ER);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs (nWAIT, MISO, ...).
// Resets to RESET_VAL so an idle-high input reads inactive out of reset.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q <= RESET_VAL;
         s2_q <= RESET_VAL;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/eq_clock_gen.sv
// 6309E quadrature clock generator: E/Q phase sequencer with /WAIT stretch
// and timeout, MMU strobe, and free-running /2 and /4 peripheral clocks.
module eq_clock_gen
   import kolibri_pkg::*;
#(
   parameter int unsigned PHASE    = PHASE_DEFAULT,
   parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT,
   parameter int unsigned CW       = 7
) (
   input  logic MHZ48,
   input  logic nRES,
   input  logic nWAIT,
   output logic MHZ24,
   output logic MHZ12,
   output logic nQ,
   output logic nE,
   output logic nSTROBE
);

   localparam int unsigned PW = (PHASE > 1) ? $clog2(PHASE) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(PHASE - 1);
   localparam logic [CW-1:0] STR_MAX = CW'(WAIT_MAX);

   phase_e          state_q, state_d;
   logic [PW-1:0]   ph_cnt_q, ph_cnt_d;
   logic [CW-1:0]   stretch_q, stretch_d;
   logic            mhz24_q, mhz24_d;
   logic            mhz12_q, mhz12_d;
   logic            nq_q, nq_d;
   logic            ne_q, ne_d;
   logic            nstrobe_q, nstrobe_d;
   logic            wait_s;

   sync2 #(.RESET_VAL(1'b1)) u_wait_sync (
      .clk   (MHZ48),
      .rst_n (nRES),
      .d     (nWAIT),
      .q     (wait_s)
   );

   always_comb begin
      state_d   = state_q;
      ph_cnt_d  = ph_cnt_q + 1'b1;
      stretch_d = stretch_q;

      if (ph_cnt_q == PH_LAST) begin
         ph_cnt_d = '0;
         case (state_q)
            S_EF: state_d = S_QR;
            S_QR: state_d = S_ER;
            S_ER: state_d = S_QF;
            S_QF: begin
               // Stretch holds the counter at terminal so each wait cycle adds exactly one clock.
               if (!wait_s && (stretch_q < STR_MAX)) begin
                  ph_cnt_d  = ph_cnt_q;
                  stretch_d = stretch_q + 1'b1;
               end else begin
                  state_d   = S_EF;
                  stretch_d = '0;
               end
            end
            default: state_d = S_EF;
         endcase
      end

      mhz24_d = ~mhz24_q;
      mhz12_d = mhz12_q ^ mhz24_q;

      // Decode from the next state so the pins move on the same edge as the state.
      ne_d      = ~e_level(state_d);
      nq_d      = ~q_level(state_d);
      nstrobe_d = (state_d != S_QR);
   end

   always_ff @(posedge MHZ48) begin
      if (!nRES) begin
         state_q   <= S_EF;
         ph_cnt_q  <= '0;
         stretch_q <= '0;
         mhz24_q   <= 1'b0;
         mhz12_q   <= 1'b0;
         nq_q      <= 1'b1;
         ne_q      <= 1'b1;
         nstrobe_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         ph_cnt_q  <= ph_cnt_d;
         stretch_q <= stretch_d;
         mhz24_q   <= mhz24_d;
         mhz12_q   <= mhz12_d;
         nq_q      <= nq_d;
         ne_q      <= ne_d;
         nstrobe_q <= nstrobe_d;
      end
   end

   assign MHZ24   = mhz24_q;
   assign MHZ12   = mhz12_q;
   assign nQ      = nq_q;
   assign nE      = ne_q;
   assign nSTROBE = nstrobe_q;

endmodule

// File: tb/tb_eq_clock_gen.sv
// Directed bench for eq_clock_gen: reset timing, free run, /WAIT stretch,
// timeout, short pulse and reset while stretched.
module tb_eq_clock_gen;

   logic MHZ48 = 1'b0;
   logic nRES  = 1'b0;
   logic nWAIT = 1'b1;
   logic MHZ24, MHZ12, nQ, nE, nSTROBE;

   int n_checks = 0;
   int n_pass   = 0;

   int t_qf, t_ef, t_qr, t_er, div_err;
   int same_edge, strobe_low, strobe_bad, bad_per, n_rise, last_rise;
   int cnt, hcnt;
   logic prev_ne, prev_nq;

   eq_clock_gen #(
      .PHASE    (4),
      .WAIT_MAX (64),
      .CW       (7)
   ) dut (
      .MHZ48   (MHZ48),
      .nRES    (nRES),
      .nWAIT   (nWAIT),
      .MHZ24   (MHZ24),
      .MHZ12   (MHZ12),
      .nQ      (nQ),
      .nE      (nE),
      .nSTROBE (nSTROBE)
   );

   always #5 MHZ48 = ~MHZ48;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge MHZ48);
      #1;
   endtask

   // Counts edges while nE stays at v; returns -1 if the limit expires.
   task automatic run_while_ne(input logic v, input int start, input int lim, output int n);
      n = start;
      while (nE === v && n < lim) begin
         step();
         n++;
      end
      if (nE === v) n = -1;
   endtask

   initial begin
      // Reset hold
      nRES  = 1'b0;
      nWAIT = 1'b1;
      repeat (10) step();
      chk("rst_nE",      int'(nE),      1);
      chk("rst_nQ",      int'(nQ),      1);
      chk("rst_nSTROBE", int'(nSTROBE), 1);
      chk("rst_MHZ24",   int'(MHZ24),   0);
      chk("rst_MHZ12",   int'(MHZ12),   0);
      chk("rst_stretch", int'(dut.stretch_q), 0);

      // First bus cycle after release
      nRES = 1'b1;
      t_qf = -1; t_ef = -1; t_qr = -1; t_er = -1; div_err = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (MHZ24 !== 1'(i % 2)) div_err++;
         if (MHZ12 !== 1'((i >> 1) % 2)) div_err++;
         if (t_qf < 0 && nQ === 1'b0) t_qf = i;
         if (t_ef < 0 && nE === 1'b0) t_ef = i;
         if (t_qr < 0 && t_ef >= 0 && nQ === 1'b1) t_qr = i;
         if (t_er < 0 && t_qr >= 0 && nE === 1'b1) t_er = i;
      end
      chk("nQ_fall_cycle", t_qf, 4);
      chk("nE_fall_cycle", t_ef, 8);
      chk("nQ_rise_cycle", t_qr, 12);
      chk("nE_rise_cycle", t_er, 16);
      chk("divider_errs",  div_err, 0);

      // Free run, 100 bus cycles starting at an nE rise
      prev_ne = nE; prev_nq = nQ;
      same_edge = 0; strobe_low = 0; strobe_bad = 0; bad_per = 0; n_rise = 0; last_rise = 0;
      for (int i = 1; i <= 1600; i++) begin
         step();
         if (nE !== prev_ne && nQ !== prev_nq) same_edge++;
         if (nSTROBE === 1'b0) begin
            strobe_low++;
            if (!(nQ === 1'b0 && nE === 1'b1)) strobe_bad++;
         end
         if (prev_ne === 1'b0 && nE === 1'b1) begin
            if (i - last_rise != 16) bad_per++;
            last_rise = i;
            n_rise++;
         end
         prev_ne = nE;
         prev_nq = nQ;
      end
      chk("free_rises",      n_rise,     100);
      chk("free_bad_period", bad_per,    0);
      chk("strobe_low_cyc",  strobe_low, 400);
      chk("strobe_outside",  strobe_bad, 0);
      chk("nE_nQ_same_edge", same_edge,  0);

      // Wait stretch: nWAIT low for 10 edges starting mid S_ER
      run_while_ne(1'b1, 0, 40, cnt);
      chk("sync_to_ER", cnt, 8);
      step();
      nWAIT = 1'b0;
      repeat (10) step();
      nWAIT = 1'b1;
      run_while_ne(1'b0, 11, 200, cnt);
      chk("stretch_E_high", cnt, 14);
      run_while_ne(1'b1, 0, 40, hcnt);
      chk("stretch_E_low", hcnt, 8);
      run_while_ne(1'b0, 0, 40, cnt);
      chk("after_stretch_E_high", cnt, 8);

      // Short pulse during S_EF
      step();
      nWAIT = 1'b0;
      step();
      nWAIT = 1'b1;
      run_while_ne(1'b1, 2, 40, cnt);
      run_while_ne(1'b0, cnt, 80, cnt);
      chk("short_pulse_period", cnt, 16);

      // Timeout with nWAIT stuck low
      nWAIT = 1'b0;
      run_while_ne(1'b1, 0, 40, cnt);
      chk("timeout_E_low_pre", cnt, 8);
      run_while_ne(1'b0, 0, 300, cnt);
      chk("timeout_E_high_1", cnt, 72);
      run_while_ne(1'b1, 0, 40, cnt);
      chk("timeout_E_low", cnt, 8);
      run_while_ne(1'b0, 0, 300, cnt);
      chk("timeout_E_high_2", cnt, 72);

      // Reset while stretched
      run_while_ne(1'b1, 0, 40, cnt);
      repeat (20) step();
      chk("mid_stretch_cnt", int'(dut.stretch_q), 13);
      chk("mid_stretch_nE",  int'(nE), 0);
      nRES = 1'b0;
      step();
      chk("rst_mid_nE",      int'(nE),      1);
      chk("rst_mid_nQ",      int'(nQ),      1);
      chk("rst_mid_nSTROBE", int'(nSTROBE), 1);
      chk("rst_mid_MHZ24",   int'(MHZ24),   0);
      nWAIT = 1'b1;
      step();
      chk("rst_mid_MHZ12",   int'(MHZ12),   0);
      nRES = 1'b1;
      run_while_ne(1'b1, 0, 40, cnt);
      chk("post_rst_nE_fall", cnt, 8);
      chk("post_rst_stretch", int'(dut.stretch_q), 0);
      run_while_ne(1'b0, 0, 200, cnt);
      chk("post_rst_E_high",  cnt, 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
